// File: rtl/hough_pkg.sv
// Shared definitions for the Hough front end.
// Holds the frame-reader FSM encoding, the default frame geometry with its
// derived coordinate widths, and the edge threshold shared with the Hough
// accumulator.
package hough_pkg;

    localparam int DEF_WIDTH          = 1280;
    localparam int DEF_HEIGHT         = 720;
    localparam int DEF_EDGE_THRESHOLD = 1;

    localparam int X_W = $clog2(DEF_WIDTH);
    localparam int Y_W = $clog2(DEF_HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        PUSH,
        DONE
    } reader_state_t;

endpackage

// File: rtl/hysteresis_bram_reader.sv
// Read-side companion of the hysteresis stage.
// On a start pulse it scans the hysteresis result BRAM in raster order. Every
// pixel at or above EDGE_THRESHOLD is written to the Hough edge FIFO as a
// {y,x} coordinate word. A one-cycle read_done pulse marks the end of the frame.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle pulse that begins a scan; it is ignored while busy
//   bram_rd_addr BRAM read address; data returns one cycle later
//   bram_rd_data 8-bit BRAM read data
//   edge_din     {y,x} coordinate word for the edge FIFO
//   edge_wr_en   edge FIFO write strobe; never asserted while edge_full is high
//   edge_full    edge FIFO full
//   busy         high while a scan is in progress (ADDR/DATA/PUSH)
//   read_done    one-cycle pulse at the end of the frame
//   edge_count   edges written this frame; held until the next start
module hysteresis_bram_reader
    import hough_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int HEIGHT         = DEF_HEIGHT,
    parameter int IMAGE_SIZE     = WIDTH * HEIGHT,
    parameter int EDGE_THRESHOLD = DEF_EDGE_THRESHOLD,
    localparam int AW = $clog2(IMAGE_SIZE),
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int CW = $clog2(IMAGE_SIZE + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    bram_rd_addr,
    input  logic [7:0]       bram_rd_data,
    output logic [YW+XW-1:0] edge_din,
    output logic             edge_wr_en,
    input  logic             edge_full,
    output logic             busy,
    output logic             read_done,
    output logic [CW-1:0]    edge_count
);

    localparam logic [7:0]    THR       = 8'(EDGE_THRESHOLD);
    localparam logic [AW-1:0] ADDR_LAST = AW'(IMAGE_SIZE - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);

    reader_state_t state, state_d;
    logic [AW-1:0] addr, addr_d;
    logic [XW-1:0] x, x_d;
    logic [YW-1:0] y, y_d;
    logic [7:0]    pixel, pixel_d;
    logic [CW-1:0] count_d;
    logic          advance;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            x          <= '0;
            y          <= '0;
            pixel      <= '0;
            edge_count <= '0;
            busy       <= 1'b0;
            read_done  <= 1'b0;
        end else begin
            state      <= state_d;
            addr       <= addr_d;
            x          <= x_d;
            y          <= y_d;
            pixel      <= pixel_d;
            edge_count <= count_d;
            // Registered from the next state so they line up with the state they describe.
            busy       <= (state_d == ADDR) || (state_d == DATA) || (state_d == PUSH);
            read_done  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d      = state;
        addr_d       = addr;
        x_d          = x;
        y_d          = y;
        pixel_d      = pixel;
        count_d      = edge_count;
        advance      = 1'b0;
        bram_rd_addr = addr;
        edge_din     = {y, x};
        edge_wr_en   = 1'b0;

        case (state)
            IDLE: begin
                bram_rd_addr = '0;
                if (start) begin
                    state_d = ADDR;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    count_d = '0;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                pixel_d = bram_rd_data;
                if (bram_rd_data >= THR) state_d = PUSH;
                else                     advance = 1'b1;
            end
            PUSH: begin
                // Coordinates stay frozen while the FIFO is full, so edge_din is stable.
                // The registered pixel re-qualifies the write; PUSH is only entered for edges.
                if (!edge_full) begin
                    advance = 1'b1;
                    if (pixel >= THR) begin
                        edge_wr_en = 1'b1;
                        count_d    = edge_count + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The last pixel goes straight to DONE; addr/x/y are left on it rather than wrapped.
        if (advance) begin
            if (addr == ADDR_LAST) begin
                state_d = DONE;
            end else begin
                state_d = ADDR;
                addr_d  = addr + 1'b1;
                if (x == X_LAST) begin
                    x_d = '0;
                    y_d = y + 1'b1;
                end else begin
                    x_d = x + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hysteresis_bram_reader.sv
module tb_hysteresis_bram_reader;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] bram_rd_addr;
    logic [7:0] bram_rd_data;
    logic [4:0] edge_din;
    logic       edge_wr_en;
    logic       edge_full = 1'b0;
    logic       busy;
    logic       read_done;
    logic [5:0] edge_count;

    logic [7:0] mem [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame observations collected by run_frame
    logic [4:0] wr_q [$];
    int         wc_q [$];
    int         done_cyc;
    int         done_pulses;
    int         full_writes;
    int         din_chg;
    logic       busy_at1;
    logic       busy_at_done;

    always #5 clk = ~clk;

    always @(posedge clk) bram_rd_data <= mem[bram_rd_addr];

    hysteresis_bram_reader #(
        .WIDTH(W),
        .HEIGHT(H),
        .EDGE_THRESHOLD(1)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .start(start),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data),
        .edge_din(edge_din),
        .edge_wr_en(edge_wr_en),
        .edge_full(edge_full),
        .busy(busy),
        .read_done(read_done),
        .edge_count(edge_count)
    );

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    // Cycle k = k-th cycle after the cycle in which start is high.
    // edge_full is driven high for cycles [fs, fs+fl); restart_cyc re-pulses start.
    task automatic run_frame(input int fs, input int fl, input int restart_cyc);
        int         cyc;
        logic       prev_full;
        logic [4:0] prev_din;
        wr_q.delete();
        wc_q.delete();
        done_cyc = -1; done_pulses = 0; full_writes = 0; din_chg = 0;
        busy_at1 = 1'b0; busy_at_done = 1'b1;
        prev_full = 1'b0; prev_din = '0;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            start     = (cyc == restart_cyc);
            edge_full = (cyc >= fs) && (cyc < fs + fl);
            @(negedge clk);
            if (cyc == 1) busy_at1 = busy;
            if (edge_wr_en) begin
                if (edge_full) full_writes++;
                wr_q.push_back(edge_din);
                wc_q.push_back(cyc);
            end
            if (edge_full && prev_full && (edge_din !== prev_din)) din_chg++;
            prev_full = edge_full;
            prev_din  = edge_din;
            if (read_done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = busy;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        start     = 1'b0;
        edge_full = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bram_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bram_rd_addr); end
        n_checks++; if (edge_din !== 5'd0) begin n_fail++; $display("FAIL reset_din got %0d want 0", edge_din); end
        n_checks++; if (edge_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", edge_wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (read_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", read_done); end
        n_checks++; if (edge_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", edge_count); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_zero;
        fill_mem(8'h00);
        run_frame(0, 0, 0);
        n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL zero_writes got %0d want 0", wr_q.size()); end
        n_checks++; if (done_cyc != 65) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 65", done_cyc); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", done_pulses); end
        n_checks++; if (edge_count !== 6'd0) begin n_fail++; $display("FAIL zero_count got %0d want 0", edge_count); end
        n_checks++; if (busy_at1 !== 1'b1) begin n_fail++; $display("FAIL zero_busy_start got %b want 1", busy_at1); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL zero_busy_done got %b want 0", busy_at_done); end
    endtask

    task automatic test_first_pixel;
        fill_mem(8'h00);
        mem[0] = 8'h30;
        run_frame(0, 0, 0);
        n_checks++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL first_writes got %0d want 1", wr_q.size()); end
        if (wr_q.size() == 1) begin
            n_checks++; if (wr_q[0] !== 5'd0) begin n_fail++; $display("FAIL first_din got %0d want 0", wr_q[0]); end
            n_checks++; if (wc_q[0] != 3) begin n_fail++; $display("FAIL first_wr_cycle got %0d want 3", wc_q[0]); end
        end
        n_checks++; if (done_cyc != 66) begin n_fail++; $display("FAIL first_done_cycle got %0d want 66", done_cyc); end
        n_checks++; if (edge_count !== 6'd1) begin n_fail++; $display("FAIL first_count got %0d want 1", edge_count); end
    endtask

    task automatic test_last_pixel;
        fill_mem(8'h00);
        mem[31] = 8'hFF;
        run_frame(0, 0, 0);
        n_checks++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL last_writes got %0d want 1", wr_q.size()); end
        if (wr_q.size() == 1) begin
            n_checks++; if (wr_q[0] !== {2'd3, 3'd7}) begin n_fail++; $display("FAIL last_din got %0d want 31", wr_q[0]); end
            n_checks++; if (wc_q[0] != 65) begin n_fail++; $display("FAIL last_wr_cycle got %0d want 65", wc_q[0]); end
        end
        n_checks++; if (done_cyc != 66) begin n_fail++; $display("FAIL last_done_cycle got %0d want 66", done_cyc); end
        n_checks++; if (edge_count !== 6'd1) begin n_fail++; $display("FAIL last_count got %0d want 1", edge_count); end
    endtask

    // Value exactly at threshold counts; row wrap from x=7 to (0,1)
    task automatic test_threshold_wrap;
        fill_mem(8'h00);
        mem[8]  = 8'h01;
        mem[15] = 8'h80;
        run_frame(0, 0, 0);
        n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL thr_writes got %0d want 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            n_checks++; if (wr_q[0] !== {2'd1, 3'd0}) begin n_fail++; $display("FAIL thr_din0 got %0d want 8", wr_q[0]); end
            n_checks++; if (wr_q[1] !== {2'd1, 3'd7}) begin n_fail++; $display("FAIL thr_din1 got %0d want 15", wr_q[1]); end
        end
        n_checks++; if (done_cyc != 67) begin n_fail++; $display("FAIL thr_done_cycle got %0d want 67", done_cyc); end
        n_checks++; if (edge_count !== 6'd2) begin n_fail++; $display("FAIL thr_count got %0d want 2", edge_count); end
    endtask

    // Every pixel is an edge; FIFO full over cycles 2..6 stalls the first PUSH (cycles 3..6)
    task automatic test_back_to_back;
        int bad;
        fill_mem(8'h0C);
        run_frame(2, 5, 0);
        bad = 0;
        n_checks++; if (wr_q.size() != 32) begin n_fail++; $display("FAIL b2b_writes got %0d want 32", wr_q.size()); end
        for (int i = 0; i < wr_q.size() && i < 32; i++) if (wr_q[i] !== 5'(i)) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_order got %0d out-of-order want 0", bad); end
        if (wc_q.size() > 0) begin
            n_checks++; if (wc_q[0] != 7) begin n_fail++; $display("FAIL b2b_first_wr got %0d want 7", wc_q[0]); end
        end
        n_checks++; if (full_writes != 0) begin n_fail++; $display("FAIL b2b_write_while_full got %0d want 0", full_writes); end
        n_checks++; if (din_chg != 0) begin n_fail++; $display("FAIL b2b_din_stall got %0d changes want 0", din_chg); end
        n_checks++; if (done_cyc != 101) begin n_fail++; $display("FAIL b2b_done_cycle got %0d want 101", done_cyc); end
        n_checks++; if (edge_count !== 6'd32) begin n_fail++; $display("FAIL b2b_count got %0d want 32", edge_count); end
    endtask

    task automatic test_start_ignored;
        fill_mem(8'h00);
        mem[3]  = 8'h05;
        mem[20] = 8'h09;
        run_frame(0, 0, 10);
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL ign_done_pulses got %0d want 1", done_pulses); end
        n_checks++; if (done_cyc != 67) begin n_fail++; $display("FAIL ign_done_cycle got %0d want 67", done_cyc); end
        n_checks++; if (edge_count !== 6'd2) begin n_fail++; $display("FAIL ign_count got %0d want 2", edge_count); end
        n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL ign_writes got %0d want 2", wr_q.size()); end
    endtask

    task automatic test_reset_mid;
        fill_mem(8'h0C);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // pixels 0 and 1 written at cycles 3 and 6; cycle 9 is pixel 2's PUSH
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (edge_wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_in_push got %b want 1", edge_wr_en); end
        n_checks++; if (edge_count !== 6'd2) begin n_fail++; $display("FAIL mid_count_pre got %0d want 2", edge_count); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (edge_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr got %b want 0", edge_wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_checks++; if (edge_count !== 6'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", edge_count); end
        n_checks++; if (bram_rd_addr !== 5'd0) begin n_fail++; $display("FAIL mid_rst_addr got %0d want 0", bram_rd_addr); end
        n_checks++; if (edge_din !== 5'd0) begin n_fail++; $display("FAIL mid_rst_din got %0d want 0", edge_din); end
        n_checks++; if (read_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b want 0", read_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_mem(8'h00);
        mem[5]  = 8'h40;
        mem[30] = 8'h01;
        run_frame(0, 0, 0);
        n_checks++; if (done_cyc != 67) begin n_fail++; $display("FAIL mid_frame_done got %0d want 67", done_cyc); end
        n_checks++; if (edge_count !== 6'd2) begin n_fail++; $display("FAIL mid_frame_count got %0d want 2", edge_count); end
        n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL mid_frame_writes got %0d want 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            n_checks++; if (wr_q[0] !== 5'd5 || wr_q[1] !== 5'd30) begin
                n_fail++; $display("FAIL mid_frame_din got %0d,%0d want 5,30", wr_q[0], wr_q[1]);
            end
        end
    endtask

    initial begin
        fill_mem(8'h00);
        test_reset();
        test_all_zero();
        test_first_pixel();
        test_last_pixel();
        test_threshold_wrap();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
